// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_pkg
// Description : Shared definitions for the serial frame loader. Holds the
//               FSM state encoding and the bit-order select values.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_PARITY = 3'd2,
        ST_DONE   = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    localparam logic ORDER_MSB_FIRST = 1'b0;
    localparam logic ORDER_LSB_FIRST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/shift_reg_dir.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_dir
// Description : N-bit bidirectional shift core. When en is high, d enters
//               at the MSB end (dir = LSB first) or the LSB end (dir = MSB
//               first).
// Ports       : clk, rst (sync, active-high), en (shift enable),
//               dir (bit order), d (serial in), q (parallel contents)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_dir
    import shift_reg_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         dir,
    input  logic         d,
    output logic [N-1:0] q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (en) begin
            if (dir == ORDER_LSB_FIRST) begin
                r_q <= {d, r_q[N-1:1]};
            end else begin
                r_q <= {r_q[N-2:0], d};
            end
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/shift_reg_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_frame_loader
// Description : Framed serial-to-parallel input register for the DAC path.
//               Collects N bits while frame is high, then updates dout
//               atomically and pulses dout_valid the cycle after. Short
//               frames and strobes after completion pulse frame_err.
// Ports       : clk, rst (sync, active-high), frame, en, d, lsb_first,
//               dout[N-1:0], dout_valid, busy, frame_err
// Config      : SHIFT_REG_FRAME_PARITY_EN - when defined, an even-parity
//               bit follows the N data bits and is checked before loading.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_frame_loader
    import shift_reg_pkg::*;
#(
    parameter int           N        = 8,
    parameter logic [N-1:0] RST_CODE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame,
    input  logic         en,
    input  logic         d,
    input  logic         lsb_first,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    output logic         busy,
    output logic         frame_err
);

    localparam int            CW         = $clog2(N + 1);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(N - 1);

    state_e        r_state;
    logic          r_order;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_dout;
    logic          r_valid;
    logic          r_err;

    logic [N-1:0]  w_buf;
    logic          w_shift_en;
    logic          w_dir;

    // Bits are only accepted while the frame is open and we are collecting
    // data. The first bit can arrive in IDLE, before order_q has been
    // latched, so the live lsb_first input steers that one.
    assign w_shift_en = frame && en && ((r_state == ST_IDLE) || (r_state == ST_SHIFT));
    assign w_dir      = (r_state == ST_IDLE) ? lsb_first : r_order;

    shift_reg_dir #(
        .N (N)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .en  (w_shift_en),
        .dir (w_dir),
        .d   (d),
        .q   (w_buf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_order <= ORDER_MSB_FIRST;
            r_cnt   <= '0;
            r_dout  <= RST_CODE;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (frame) begin
                        r_state <= ST_SHIFT;
                        r_order <= lsb_first;
                        r_cnt   <= en ? CW'(1) : '0;
                    end
                end
                ST_SHIFT: begin
                    if (!frame) begin
                        // Short frame: partial buffer is simply abandoned.
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (en) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == c_CNT_LAST) begin
`ifdef SHIFT_REG_FRAME_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_DONE;
`endif
                        end
                    end
                end
`ifdef SHIFT_REG_FRAME_PARITY_EN
                ST_PARITY: begin
                    if (!frame) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (en) begin
                        if (^{w_buf, d} == 1'b0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_HOLD;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    r_dout  <= w_buf;
                    r_valid <= 1'b1;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!frame) begin
                        r_state <= ST_IDLE;
                    end else if (en) begin
                        // Overrun: extra strobe after a complete word.
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign frame_err  = r_err;
    assign busy       = (r_state == ST_SHIFT) || (r_state == ST_PARITY);

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_reg_frame_loader
// Description : Self-checking bench for shift_reg_frame_loader (N=8).
//               Expected words are queued as frames are sent and compared
//               whenever dout_valid is seen. Parity cases are included when
//               SHIFT_REG_FRAME_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_reg_frame_loader;

    localparam int           N        = 8;
    localparam logic [N-1:0] RST_CODE = 8'h81;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame;
    logic         en;
    logic         d;
    logic         lsb_first;
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         busy;
    logic         frame_err;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_valid  = 0;
    int           n_err    = 0;
    logic [N-1:0] sb_q[$];

    shift_reg_frame_loader #(
        .N        (N),
        .RST_CODE (RST_CODE)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .frame      (frame),
        .en         (en),
        .d          (d),
        .lsb_first  (lsb_first),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] rev8(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[N-1-i];
        return r;
    endfunction

    // Scoreboard side: every valid pulse must match the oldest queued word.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) n_err++;
            if (dout_valid) begin
                n_valid++;
                if (sb_q.size() == 0) check("sb_unexpected_valid", 32'(dout_valid), 32'd0);
                else                  check("sb_dout", 32'(dout), 32'(sb_q.pop_front()));
            end
        end
    end

    // Apply inputs, let one rising edge sample them, return just after it.
    task automatic cyc(input logic f, input logic e, input logic b);
        frame = f;
        en    = e;
        d     = b;
        @(posedge clk);
        #1;
    endtask

    // Sends the first nbits of seq, seq[7] first. gap idle cycles (frame
    // high, en low, d inverted) separate strobes. tog flips lsb_first from
    // the fourth bit onward, which must not matter.
    task automatic send_seq(input logic [N-1:0] seq, input logic lsb, input int nbits,
                            input int gap, input bit tog);
        for (int i = 0; i < nbits; i++) begin
            lsb_first = (tog && i >= 3) ? ~lsb : lsb;
            cyc(1'b1, 1'b1, seq[N-1-i]);
            if (i != nbits - 1) repeat (gap) cyc(1'b1, 1'b0, ~seq[N-1-i]);
        end
    endtask

    // Complete frame with frame still high afterwards (DUT ends in HOLD).
    task automatic full_frame(input logic [N-1:0] seq, input logic lsb, input int gap,
                              input bit tog);
        logic [N-1:0] exp;
        exp = lsb ? rev8(seq) : seq;
        sb_q.push_back(exp);
        send_seq(seq, lsb, N, gap, tog);
`ifdef SHIFT_REG_FRAME_PARITY_EN
        check("busy_in_parity", 32'(busy), 32'd1);
        cyc(1'b1, 1'b1, ^exp);
`endif
        check("busy_after_last", 32'(busy), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        check("valid_latency", 32'(dout_valid), 32'd1);
        check("dout_latency", 32'(dout), 32'(exp));
        cyc(1'b1, 1'b0, 1'b0);
        check("valid_one_cycle", 32'(dout_valid), 32'd0);
    endtask

    int v0;
    int e0;

    initial begin
        rst       = 1'b1;
        frame     = 1'b0;
        en        = 1'b0;
        d         = 1'b0;
        lsb_first = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'(RST_CODE));
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 1'b1);   // en with frame low: ignored
        check("idle_en_busy", 32'(busy), 32'd0);

        // MSB first, 1,0,1,1,0,0,1,0 -> B2
        v0 = n_valid; e0 = n_err;
        full_frame(8'hB2, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("msb_err_cnt", 32'(n_err - e0), 32'd0);
        check("msb_valid_cnt", 32'(n_valid - v0), 32'd1);

        // Same bits LSB first, lsb_first toggled mid-frame -> 4D
        full_frame(8'hB2, 1'b1, 0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        // Short frame: strobe every 3rd cycle, drop after 5 bits
        e0 = n_err; v0 = n_valid;
        send_seq(8'hE8, 1'b0, 5, 2, 1'b0);
        check("short_busy", 32'(busy), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        check("short_err", 32'(frame_err), 32'd1);
        check("short_busy_fall", 32'(busy), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        check("short_err_pulse", 32'(frame_err), 32'd0);
        check("short_dout_kept", 32'(dout), 32'h4D);
        check("short_err_cnt", 32'(n_err - e0), 32'd1);
        check("short_valid_cnt", 32'(n_valid - v0), 32'd0);

        // A5 then two overrun strobes before frame falls
        e0 = n_err; v0 = n_valid;
        full_frame(8'hA5, 1'b0, 1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        check("overrun_err", 32'(frame_err), 32'd1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("overrun_dout", 32'(dout), 32'hA5);
        check("overrun_err_cnt", 32'(n_err - e0), 32'd2);
        check("overrun_valid_cnt", 32'(n_valid - v0), 32'd1);

        // Reset after 4 bits, then a clean 3C frame
        send_seq(8'hF0, 1'b0, 4, 0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        check("midrst_dout", 32'(dout), 32'(RST_CODE));
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        full_frame(8'h3C, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // en high as frame falls after 7 bits, then immediate new frame
        e0 = n_err;
        send_seq(8'h00, 1'b0, 7, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        check("fall_en_err", 32'(frame_err), 32'd1);
        check("fall_en_dout", 32'(dout), 32'h3C);
        full_frame(8'h96, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("fall_en_err_cnt", 32'(n_err - e0), 32'd1);

`ifdef SHIFT_REG_FRAME_PARITY_EN
        // 0F with correct parity loads; 0F with wrong parity is rejected
        full_frame(8'h0F, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        v0 = n_valid;
        send_seq(8'h0F, 1'b0, N, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        check("par_bad_err", 32'(frame_err), 32'd1);
        check("par_bad_valid", 32'(dout_valid), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        check("par_bad_valid2", 32'(dout_valid), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("par_bad_dout", 32'(dout), 32'h0F);
        check("par_bad_valid_cnt", 32'(n_valid - v0), 32'd0);
`endif

        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
